instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the core's instruction decoder: takes a decoded instruction class plus fields (funct3/funct7, src1/src2/des, imm12/imm20) and assembles the 32-bit instruction word.
- Each word is paired with a sequential instruction-memory word address.
- Results are buffered in a small FIFO for the program loader / self-test path that fills instruction memory.
- Field placement is the exact inverse of decoder field extraction, so decode(encode(x)) round-trips field-for-field.

Parameters:
- DEPTH, 2, output FIFO entries (>=2).
- ADDR_W, 10, width of the word-address counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  request carries a valid instruction description.
- in_ready  out  1  encoder can accept; equals (count < DEPTH).
- op_type  in  4  0=R, 1=I(ALU imm), 2=LOAD, 3=STORE, 4=BRANCH, 5=JALR, 6=LUI, 7=AUIPC, 8=JAL; 9-15 illegal.
- funct3  in  3  function code.
- funct7  in  7  R-type upper function bits.
- src1  in  5  rs1.
- src2  in  5  rs2.
- des  in  5  rd.
- imm12  in  12  12-bit immediate.
- imm20  in  20  20-bit immediate.
- addr_load  in  1  load address counter from addr_base.
- addr_base  in  ADDR_W  base word address.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head.
- out_instr  out  32  encoded word at head.
- out_addr  out  ADDR_W  word address of head.
- err  out  1  one-cycle pulse: illegal op_type accepted.
- instr_count  out  16  number of words popped; wraps.

Behaviour:
- Reset (async, rst_n=0): count=0, wr/rd pointers=0, addr counter=0, err=0, instr_count=0.
  - out_valid=0; out_instr and out_addr are forced to 0 whenever out_valid=0.
  - in_ready=1 after reset; inputs are ignored while rst_n=0.
  - Reset mid-operation discards all buffered entries immediately.
- Accept: in_valid & in_ready at a rising edge.
- Legal op_type: encoded word plus the current address are written to the FIFO tail. Visible at out_* the next cycle if the FIFO was empty (latency 1).
- Encoding (opcode in [6:0]; all fields placed raw, no ISA immediate scrambling):
  - R: {funct7, src2, src1, funct3, des, 0110011}.
  - I: {imm12, src1, funct3, des, 0010011}.
  - LOAD: {imm12, src1, funct3, des, 0000011}.
  - JALR: {imm12, src1, funct3, des, 1100111}.
  - STORE: {imm12[11:5], src2, src1, funct3, imm12[4:0], 0100011}.
  - BRANCH: {imm12[11:5], src2, src1, funct3, imm12[4:0], 1100011}.
  - LUI: {imm20, des, 0110111}.
  - AUIPC: {imm20, des, 0010111}.
  - JAL: {imm20, des, 1101111}.
  - Unused inputs are ignored.
- Address counter:
  - Increments by 1 per accepted legal instruction; wraps modulo 2^ADDR_W.
  - addr_load with no accept: counter <= addr_base.
  - addr_load with a legal accept in the same cycle: the entry gets addr_base and the counter <= addr_base+1.
- Illegal op_type accepted:
  - Nothing enqueued; address counter not advanced (addr_load still honoured).
  - err=1 for exactly the following cycle.
  - in_ready still applies, so an illegal request is consumed.
- FIFO:
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged; pointers wrap at DEPTH.
  - When full, in_ready=0 regardless of out_ready (no pass-through).
  - Order preserved strictly.
  - out_instr and out_addr are stable while out_valid & !out_ready.
- instr_count increments on each pop.

Test Plan:
- R add: op_type=0, funct7=0, funct3=0, src1=1, src2=2, des=3 after reset -> next cycle out_valid=1, out_instr=0x002081B3, out_addr=0; pop -> instr_count=1.
- I addi: op_type=1, imm12=0xFFF, src1=0, funct3=0, des=5 -> 0xFFF00293. LUI: op_type=6, imm20=0x12345, des=10 -> 0x12345537.
- STORE sw: op_type=3, funct3=2, src1=1, src2=2, imm12=0x008 -> 0x0020A423. Feeding each word to decoder returns the identical fields.
- Backpressure, DEPTH=2, out_ready=0, three back-to-back requests:
  - in_ready drops after the 2nd; the 3rd is held.
  - Raising out_ready yields the words in order at addresses 0,1,2.
  - A push+pop in the same cycle keeps count unchanged.
- Illegal op_type=9 accepted -> err high exactly one cycle, out_valid unchanged, next legal word gets the unadvanced address.
- addr_load=1, addr_base=0x040 in the same cycle as an accept -> out_addr=0x040, next accepted word 0x041. Counter at 0x3FF -> next word 0x3FF, following 0x000. rst_n low with 2 entries buffered -> out_valid=0 and out_instr=0 immediately.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: assembles a 32-bit instruction word from a decoded
// instruction class plus its fields, tags it with a sequential word address,
// and queues the pair in a small FIFO for the instruction-memory loader.
// Field placement mirrors the decoder's extraction, so decoding a produced
// word returns the same fields.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    request handshake (in_ready = FIFO not full)
//   op_type                0=R 1=I 2=LOAD 3=STORE 4=BRANCH 5=JALR 6=LUI
//                          7=AUIPC 8=JAL; 9-15 illegal
//   funct3, funct7         function codes
//   src1, src2, des        rs1, rs2, rd
//   imm12, imm20           raw immediates
//   addr_load, addr_base   reload of the word-address counter
//   out_valid / out_ready  FIFO head handshake
//   out_instr, out_addr    head word and its address (0 when empty)
//   err                    one-cycle pulse after an illegal request is taken
//   instr_count            words popped, wraps at 16 bits
module instr_encoder #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op_type,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        src1,
    input  logic [4:0]        src2,
    input  logic [4:0]        des,
    input  logic [11:0]       imm12,
    input  logic [19:0]       imm20,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_base,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [15:0]       instr_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    function automatic logic [31:0] encode(
        input logic [3:0]  op,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [4:0]  rd,
        input logic [11:0] i12,
        input logic [19:0] i20
    );
        logic [31:0] w;
        w = 32'd0;
        case (op)
            4'd0: w = {f7, rs2, rs1, f3, rd, 7'b0110011};
            4'd1: w = {i12, rs1, f3, rd, 7'b0010011};
            4'd2: w = {i12, rs1, f3, rd, 7'b0000011};
            4'd3: w = {i12[11:5], rs2, rs1, f3, i12[4:0], 7'b0100011};
            4'd4: w = {i12[11:5], rs2, rs1, f3, i12[4:0], 7'b1100011};
            4'd5: w = {i12, rs1, f3, rd, 7'b1100111};
            4'd6: w = {i20, rd, 7'b0110111};
            4'd7: w = {i20, rd, 7'b0010111};
            4'd8: w = {i20, rd, 7'b1101111};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    logic [31:0]       instr_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [15:0]       icnt_q, icnt_d;

    logic              legal;
    logic              accept;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] entry_addr;
    logic [31:0]       word;

    assign legal      = (op_type <= 4'd8);
    assign in_ready   = (count_q < CNT_W'(DEPTH));
    assign out_valid  = (count_q != '0);
    assign accept     = in_valid & in_ready;
    assign push       = accept & legal;
    assign pop        = out_valid & out_ready;
    // A same-cycle reload takes effect for the entry being written.
    assign entry_addr = addr_load ? addr_base : addr_q;
    assign word       = encode(op_type, funct3, funct7, src1, src2, des, imm12, imm20);

    assign out_instr   = out_valid ? instr_mem[rd_ptr_q] : 32'd0;
    assign out_addr    = out_valid ? addr_mem[rd_ptr_q] : '0;
    assign err         = err_q;
    assign instr_count = icnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        err_d    = accept & ~legal;
        icnt_d   = icnt_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            icnt_d   = icnt_q + 16'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push) begin
            addr_d = entry_addr + 1'b1;
        end else if (addr_load) begin
            addr_d = addr_base;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            icnt_q   <= 16'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
            icnt_q   <= icnt_d;
        end
    end

    // Storage carries no reset: out_* are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= word;
            addr_mem[wr_ptr_q]  <= entry_addr;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int DEPTH  = 2;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        op_type = '0;
    logic [2:0]        funct3 = '0;
    logic [6:0]        funct7 = '0;
    logic [4:0]        src1 = '0;
    logic [4:0]        src2 = '0;
    logic [4:0]        des = '0;
    logic [11:0]       imm12 = '0;
    logic [19:0]       imm20 = '0;
    logic              addr_load = 1'b0;
    logic [ADDR_W-1:0] addr_base = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic [15:0]       instr_count;

    int n_vec = 0;
    int n_bad = 0;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_type(op_type), .funct3(funct3), .funct7(funct7),
        .src1(src1), .src2(src2), .des(des),
        .imm12(imm12), .imm20(imm20),
        .addr_load(addr_load), .addr_base(addr_base),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err(err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_enc(int op, int f3, int f7, int s1, int s2,
                                            int rd, int i12, int i20);
        int opc [9] = '{'h33, 'h13, 'h03, 'h23, 'h63, 'h67, 'h37, 'h17, 'h6F};
        longint w;
        if (op > 8) return 32'd0;
        w = opc[op];
        if (op == 0)
            w = w + rd * 2**7 + f3 * 2**12 + s1 * 2**15 + s2 * 2**20 + f7 * 2**25;
        else if (op == 1 || op == 2 || op == 5)
            w = w + rd * 2**7 + f3 * 2**12 + s1 * 2**15 + longint'(i12) * 2**20;
        else if (op == 3 || op == 4)
            w = w + (i12 % 32) * 2**7 + f3 * 2**12 + s1 * 2**15 + s2 * 2**20
                  + longint'(i12 / 32) * 2**25;
        else
            w = w + rd * 2**7 + longint'(i20) * 2**12;
        return w[31:0];
    endfunction

    logic [31:0] q_instr [$];
    int          q_addr  [$];
    int          m_addr = 0;
    bit          m_err = 0;
    int          m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_instr.delete();
            q_addr.delete();
            m_addr = 0;
            m_err  = 0;
            m_cnt  = 0;
        end else begin
            bit acc, pp;
            int ea;
            acc = in_valid && (q_instr.size() < DEPTH);
            pp  = (q_instr.size() > 0) && out_ready;
            if (pp) begin
                void'(q_instr.pop_front());
                void'(q_addr.pop_front());
                m_cnt = (m_cnt + 1) % 65536;
            end
            m_err = acc && (op_type > 8);
            ea = addr_load ? int'(addr_base) : m_addr;
            if (acc && op_type <= 8) begin
                q_instr.push_back(ref_enc(op_type, funct3, funct7, src1, src2, des,
                                          imm12, imm20));
                q_addr.push_back(ea);
                m_addr = (ea + 1) % (2**ADDR_W);
            end else if (addr_load) begin
                m_addr = addr_base;
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    // Cycle-by-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        bit ev;
        ev = q_instr.size() > 0;
        chk("in_ready", in_ready, q_instr.size() < DEPTH);
        chk("out_valid", out_valid, ev);
        chk("out_instr", out_instr, ev ? q_instr[0] : 32'd0);
        chk("out_addr", out_addr, ev ? q_addr[0] : 0);
        chk("err", err, m_err);
        chk("instr_count", instr_count, m_cnt);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int op, int f3, int f7, int s1, int s2, int rd, int i12, int i20);
        op_type = op[3:0]; funct3 = f3[2:0]; funct7 = f7[6:0];
        src1 = s1[4:0]; src2 = s2[4:0]; des = rd[4:0];
        imm12 = i12[11:0]; imm20 = i20[19:0];
    endtask

    task automatic send();
        int  n;
        bit  acc;
        n = 0;
        in_valid = 1'b1;
        do begin
            acc = in_ready;
            step();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid  = 1'b0;
        addr_load = 1'b0;
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        step();
        #2 rst_n = 1'b1;
        step();
    endtask

    initial begin
        // model pinned against hand-computed words
        chk("ref_add",   ref_enc(0, 0, 0, 1, 2, 3, 0, 0),       32'h002081B3);
        chk("ref_addi",  ref_enc(1, 0, 0, 0, 0, 5, 'hFFF, 0),   32'hFFF00293);
        chk("ref_lui",   ref_enc(6, 0, 0, 0, 0, 10, 0, 'h12345), 32'h12345537);
        chk("ref_sw",    ref_enc(3, 2, 0, 1, 2, 0, 'h008, 0),   32'h0020A423);

        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        step();

        // R add, latency 1, pop counting
        set_req(0, 0, 0, 1, 2, 3, 0, 0);
        send();
        chk("add_valid", out_valid, 1);
        chk("add_instr", out_instr, 32'h002081B3);
        chk("add_addr", out_addr, 0);
        chk("add_rt_rd", out_instr[11:7], 3);
        chk("add_rt_rs1", out_instr[19:15], 1);
        chk("add_rt_rs2", out_instr[24:20], 2);
        pop1();
        chk("add_count", instr_count, 1);

        set_req(1, 0, 0, 0, 0, 5, 'hFFF, 0);
        send();
        chk("addi_instr", out_instr, 32'hFFF00293);
        pop1();
        set_req(6, 0, 0, 0, 0, 10, 0, 'h12345);
        send();
        chk("lui_instr", out_instr, 32'h12345537);
        chk("lui_rt_imm", out_instr[31:12], 'h12345);
        pop1();
        set_req(3, 2, 0, 1, 2, 0, 'h008, 0);
        send();
        chk("sw_instr", out_instr, 32'h0020A423);
        chk("sw_rt_imm", {out_instr[31:25], out_instr[11:7]}, 'h008);
        chk("sw_rt_f3", out_instr[14:12], 2);
        pop1();

        // backpressure
        do_reset();
        set_req(0, 0, 0, 1, 1, 1, 0, 0); send();
        set_req(0, 0, 0, 2, 2, 2, 0, 0); send();
        chk("bp_full_ready", in_ready, 0);
        set_req(0, 0, 0, 3, 3, 3, 0, 0);
        in_valid = 1'b1;
        step(); step();
        chk("bp_held_addr", out_addr, 0);
        chk("bp_held_ready", in_ready, 0);
        out_ready = 1'b1;
        step();
        chk("bp_addr1", out_addr, 1);
        chk("bp_ready1", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_addr2", out_addr, 2);
        chk("bp_pushpop_ready", in_ready, 1);
        step();
        out_ready = 1'b0;
        chk("bp_empty", out_valid, 0);

        // illegal op_type
        do_reset();
        set_req(1, 0, 0, 4, 0, 4, 'h10, 0); send();
        set_req(9, 0, 0, 0, 0, 0, 0, 0); send();
        chk("ill_err", err, 1);
        chk("ill_valid", out_valid, 1);
        chk("ill_ready", in_ready, 1);
        step();
        chk("ill_err_clr", err, 0);
        set_req(1, 0, 0, 5, 0, 5, 'h20, 0); send();
        pop1();
        chk("ill_next_addr", out_addr, 1);
        pop1();

        // address reload and wrap
        do_reset();
        addr_load = 1'b1; addr_base = 10'h040;
        set_req(8, 0, 0, 0, 0, 1, 0, 'hABCDE); send();
        chk("ld_addr", out_addr, 'h040);
        pop1();
        set_req(7, 0, 0, 0, 0, 2, 0, 'h00F0F); send();
        chk("ld_next", out_addr, 'h041);
        pop1();
        addr_load = 1'b1; addr_base = 10'h3FF;
        step();
        addr_load = 1'b0;
        set_req(4, 5, 0, 6, 7, 0, 'hA5A, 0); send();
        chk("wrap_top", out_addr, 'h3FF);
        pop1();
        set_req(5, 0, 0, 8, 0, 9, 'h123, 0); send();
        chk("wrap_zero", out_addr, 0);
        pop1();

        // reset with two entries buffered
        set_req(2, 3, 0, 1, 0, 2, 'h7, 0); send();
        set_req(2, 3, 0, 1, 0, 3, 'h8, 0); send();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_instr", out_instr, 0);
        chk("mid_rst_ready", in_ready, 1);
        step();
        #2 rst_n = 1'b1;
        step();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            set_req(($urandom % 8 == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8),
                    $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            addr_load = ($urandom % 25) == 0;
            addr_base = ADDR_W'($urandom);
            if (i % 200 == 199) rst_n = 1'b0;
            else rst_n = 1'b1;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        addr_load = 1'b0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
